// File: rtl/cache_ctrl.sv
// Sequencing controller for a 2-way, 4-set, one-word-per-line data cache.
// Owns tag/valid/dirty/MRU/data state and drives a single-outstanding memory handshake.
module cache_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int TAG_W = ADDR_W - 4;

    typedef enum logic [2:0] {IDLE, TAG, WB, FILL, DONE} state_t;

    state_t state_q, state_d;

    logic              req_we_q;
    logic [ADDR_W-1:2] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;

    logic [TAG_W-1:0]  tag_mem  [2][4];
    logic [DATA_W-1:0] data_mem [2][4];
    logic [1:0]        valid_q  [4];
    logic [1:0]        dirty_q  [4];
    logic [3:0]        mru_q;
    logic              victim_q;

    logic [1:0]       idx;
    logic [TAG_W-1:0] req_tag;
    logic             hit0, hit1, hit, hit_way, miss_victim;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr[1:0];

    assign idx     = req_addr_q[3:2];
    assign req_tag = req_addr_q[ADDR_W-1:4];
    assign hit0    = valid_q[idx][0] && (tag_mem[0][idx] == req_tag);
    assign hit1    = valid_q[idx][1] && (tag_mem[1][idx] == req_tag);
    assign hit     = hit0 || hit1;
    // Way 0 wins if both ways claim the line.
    assign hit_way = !hit0;
    assign miss_victim = !valid_q[idx][0] ? 1'b0 :
                         !valid_q[idx][1] ? 1'b1 : !mru_q[idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cpu_ready = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: if (cpu_req) state_d = TAG;
            TAG: begin
                if (hit)
                    state_d = DONE;
                else if (valid_q[idx][miss_victim] && dirty_q[idx][miss_victim])
                    state_d = WB;
                else
                    state_d = FILL;
            end
            WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_mem[victim_q][idx], idx, 2'b00};
                mem_wdata = data_mem[victim_q][idx];
                if (mem_ack) state_d = FILL;
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, idx, 2'b00};
                if (mem_ack) state_d = TAG;
            end
            DONE: begin
                cpu_ready = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            valid_q     <= '{default: '0};
            dirty_q     <= '{default: '0};
            mru_q       <= '0;
            victim_q    <= 1'b0;
            cpu_rdata   <= '0;
        end else begin
            case (state_q)
                IDLE: if (cpu_req) begin
                    req_we_q    <= cpu_we;
                    req_addr_q  <= cpu_addr[ADDR_W-1:2];
                    req_wdata_q <= cpu_wdata;
                end
                TAG: begin
                    if (hit) begin
                        cpu_rdata  <= req_we_q ? req_wdata_q : data_mem[hit_way][idx];
                        mru_q[idx] <= hit_way;
                        if (req_we_q) dirty_q[idx][hit_way] <= 1'b1;
                    end else begin
                        victim_q <= miss_victim;
                    end
                end
                WB: if (mem_ack) dirty_q[idx][victim_q] <= 1'b0;
                FILL: if (mem_ack) begin
                    valid_q[idx][victim_q] <= 1'b1;
                    dirty_q[idx][victim_q] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (state_q == TAG && hit && req_we_q)
            data_mem[hit_way][idx] <= req_wdata_q;
        if (state_q == FILL && mem_ack) begin
            data_mem[victim_q][idx] <= mem_rdata;
            tag_mem[victim_q][idx]  <= req_tag;
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: acts as CPU and memory, checks against a per-set cache model.
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
    logic        cpu_ready;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t        exp_q[$];
    logic        m_valid [4][2];
    logic        m_dirty [4][2];
    logic [27:0] m_tag   [4][2];
    logic [31:0] m_data  [4][2];
    int          m_mru   [4];
    logic [31:0] backing [logic [31:0]];

    cache_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int s = 0; s < 4; s++) begin
            m_mru[s] = 0;
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] line);
        if (!backing.exists(line)) backing[line] = $urandom;
        return backing[line];
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    // One CPU access: predict with the model, then run the DUT acting as memory.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input int wwb, input int wfill,
                             output bit saw_mem, output logic [31:0] got_rdata);
        int          idx, hw, v, n, waitc, exp_cycles, limit;
        logic [27:0] tg;
        logic [31:0] line, exp_rdata;
        txn_t        t;
        bit          done;
        idx  = int'(addr[3:2]);
        tg   = addr[31:4];
        line = {addr[31:2], 2'b00};
        hw   = -1;
        exp_cycles = 2;
        exp_q.delete();
        for (int w = 1; w >= 0; w--)
            if (m_valid[idx][w] && m_tag[idx][w] == tg) hw = w;
        if (hw < 0) begin
            if (!m_valid[idx][0])      v = 0;
            else if (!m_valid[idx][1]) v = 1;
            else                       v = 1 - m_mru[idx];
            if (m_valid[idx][v] && m_dirty[idx][v]) begin
                t.we = 1'b1;
                t.addr = {m_tag[idx][v], addr[3:2], 2'b00};
                t.wdata = m_data[idx][v];
                t.rdata = '0;
                exp_q.push_back(t);
                backing[t.addr] = t.wdata;
                exp_cycles += 1 + wwb;
            end
            t.we = 1'b0;
            t.addr = line;
            t.wdata = '0;
            t.rdata = mem_read(line);
            exp_q.push_back(t);
            exp_cycles += 2 + wfill;
            m_data[idx][v]  = t.rdata;
            m_tag[idx][v]   = tg;
            m_valid[idx][v] = 1'b1;
            m_dirty[idx][v] = 1'b0;
            hw = v;
        end
        if (we) begin
            m_data[idx][hw]  = wdata;
            m_dirty[idx][hw] = 1'b1;
        end
        exp_rdata  = m_data[idx][hw];
        m_mru[idx] = hw;

        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        tick();
        n = 0; waitc = 0; done = 1'b0; saw_mem = 1'b0; got_rdata = '0;
        limit = exp_cycles + 40;
        while (!done && n < limit) begin
            n++;
            // Anything the CPU drives now must be ignored by the DUT.
            cpu_addr = $urandom; cpu_wdata = $urandom; cpu_we = 1'($urandom);
            if (mem_ack) begin
                mem_ack = 1'b0;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                waitc = 0;
            end
            if (mem_req) begin
                saw_mem = 1'b1;
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_mem_req addr=%h got mem_we=%0b mem_addr=%h, expected no request",
                             addr, mem_we, mem_addr);
                end else begin
                    if (mem_we !== exp_q[0].we || mem_addr !== exp_q[0].addr ||
                        (exp_q[0].we && mem_wdata !== exp_q[0].wdata)) begin
                        errors++;
                        $display("FAIL mem_beat got we=%0b addr=%h wdata=%h, expected we=%0b addr=%h wdata=%h",
                                 mem_we, mem_addr, mem_wdata, exp_q[0].we, exp_q[0].addr, exp_q[0].wdata);
                    end
                    if (waitc == (exp_q[0].we ? wwb : wfill)) begin
                        mem_ack = 1'b1;
                        mem_rdata = exp_q[0].rdata;
                    end else begin
                        waitc++;
                        mem_rdata = $urandom;
                    end
                end
            end
            if (cpu_ready) begin
                done = 1'b1;
                got_rdata = cpu_rdata;
                vectors++;
                if (cpu_rdata !== exp_rdata) begin
                    errors++;
                    $display("FAIL cpu_rdata addr=%h got %h, expected %h", addr, cpu_rdata, exp_rdata);
                end
                vectors++;
                if (n != exp_cycles) begin
                    errors++;
                    $display("FAIL latency addr=%h got %0d cycles, expected %0d", addr, n, exp_cycles);
                end
                vectors++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL missing_mem_beats addr=%h got %0d outstanding, expected 0", addr, exp_q.size());
                end
            end
            if (!done) tick();
        end
        if (!done) begin
            errors++;
            $display("FAIL timeout addr=%h got no cpu_ready in %0d cycles, expected %0d", addr, n, exp_cycles);
        end
        cpu_req = 1'b0;
        mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({cpu_ready, mem_req, mem_we} !== 3'b000 || mem_addr !== '0 || mem_wdata !== '0 || cpu_rdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ready=%0b req=%0b we=%0b addr=%h wdata=%h rdata=%h, expected all 0",
                     cpu_ready, mem_req, mem_we, mem_addr, mem_wdata, cpu_rdata);
        end
        apply_reset();
        tick();
        vectors++;
        if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got req=%0b ready=%0b, expected 0 0", mem_req, cpu_ready);
        end
    endtask

    task automatic test_cold_miss_hit();
        bit          sm;
        logic [31:0] rd;
        apply_reset();
        backing[32'h10] = 32'hDEADBEEF;
        do_access(1'b0, 32'h10, '0, 0, 0, sm, rd);
        vectors++;
        if (sm !== 1'b1 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL cold_miss got mem=%0b rdata=%h, expected 1 deadbeef", sm, rd);
        end
        do_access(1'b0, 32'h10, '0, 0, 0, sm, rd);
        vectors++;
        if (sm !== 1'b0 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL warm_hit got mem=%0b rdata=%h, expected 0 deadbeef", sm, rd);
        end
    endtask

    task automatic test_lru_eviction();
        bit          sm;
        logic [31:0] rd;
        bit          exp_mem [6] = '{1, 1, 0, 1, 0, 1};
        logic [31:0] seq     [6] = '{32'h00, 32'h10, 32'h00, 32'h20, 32'h00, 32'h10};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            do_access(1'b0, seq[i], '0, 0, 0, sm, rd);
            vectors++;
            if (sm !== exp_mem[i]) begin
                errors++;
                $display("FAIL lru_step%0d addr=%h got mem=%0b, expected %0b", i, seq[i], sm, exp_mem[i]);
            end
        end
    endtask

    task automatic test_dirty_wb(input int wwb, input int wfill);
        bit          sm;
        logic [31:0] rd;
        apply_reset();
        do_access(1'b1, 32'h00, 32'h12345678, 0, 0, sm, rd);
        vectors++;
        if (rd !== 32'h12345678) begin
            errors++;
            $display("FAIL store_rdata got %h, expected 12345678", rd);
        end
        do_access(1'b0, 32'h10, '0, 0, 0, sm, rd);
        do_access(1'b0, 32'h20, '0, wwb, wfill, sm, rd);
        vectors++;
        if (backing[32'h00] !== 32'h12345678) begin
            errors++;
            $display("FAIL writeback_data got %h, expected 12345678", backing[32'h00]);
        end
        do_access(1'b0, 32'h00, '0, 0, 0, sm, rd);
        vectors++;
        if (rd !== 32'h12345678) begin
            errors++;
            $display("FAIL reload_after_wb got %h, expected 12345678", rd);
        end
    endtask

    task automatic test_reset_mid_fill();
        bit          sm;
        logic [31:0] rd;
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0344; cpu_wdata = '0;
        tick();
        cpu_req = 1'b0;
        tick();
        tick();
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0344) begin
            errors++;
            $display("FAIL fill_started got req=%0b addr=%h, expected 1 00000344", mem_req, mem_addr);
        end
        tick();
        rst = 1'b1;
        #1;
        vectors++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || cpu_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got req=%0b we=%0b addr=%h ready=%0b, expected all 0",
                     mem_req, mem_we, mem_addr, cpu_ready);
        end
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        do_access(1'b0, 32'h0000_0344, '0, 1, 2, sm, rd);
        vectors++;
        if (sm !== 1'b1) begin
            errors++;
            $display("FAIL refill_after_reset got mem=%0b, expected 1", sm);
        end
    endtask

    task automatic test_ignored_inputs();
        bit          sm;
        logic [31:0] rd;
        apply_reset();
        do_access(1'b0, 32'h0000_0ab8, '0, 0, 3, sm, rd);
        for (int i = 0; i < 4; i++) begin
            mem_ack = 1'b1;
            mem_rdata = $urandom;
            tick();
            vectors++;
            if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin
                errors++;
                $display("FAIL idle_ack got req=%0b ready=%0b, expected 0 0", mem_req, cpu_ready);
            end
        end
        mem_ack = 1'b0;
        do_access(1'b0, 32'h0000_0ab8, '0, 0, 0, sm, rd);
        vectors++;
        if (sm !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack_hit got mem=%0b, expected 0", sm);
        end
    endtask

    task automatic test_random(input int count);
        bit          sm;
        logic [31:0] rd, a;
        apply_reset();
        for (int i = 0; i < count; i++) begin
            a = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'($urandom)};
            a[31:28] = 4'($urandom_range(0, 1));
            do_access(1'($urandom), a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), sm, rd);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss_hit();
        test_lru_eviction();
        test_dirty_wb(0, 0);
        test_dirty_wb(5, 5);
        test_reset_mid_fill();
        test_ignored_inputs();
        test_random(300);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
